// File: rtl/sparc_rf_pkg.sv
// sparc_rf_pkg: shared widths, %g0 address and state/grant encodings for the register-file sequencer
package sparc_rf_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] G0_ADDR = '0;
  typedef enum logic [1:0] {IDLE, RD_A, RD_B, RESP} state_e;
  typedef enum logic {GRANT_RD, GRANT_WB} grant_e;
endpackage

// File: rtl/rf_port_sequencer_if.sv
// rf_port_sequencer_if: requester handshakes plus the single-port register-file bus
interface rf_port_sequencer_if;
  import sparc_rf_pkg::*;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_rs1;
  logic [ADDR_W-1:0] rd_rs2;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              rf_reg_write;
  logic [ADDR_W-1:0] rf_reg_adress;
  logic [DATA_W-1:0] rf_data_write;
  logic [DATA_W-1:0] rf_data_read;
  modport slave (
    input  rd_valid, rd_rs1, rd_rs2, op_ready, wb_valid, wb_rd, wb_data, rf_data_read,
    output rd_ready, op_valid, op_a, op_b, wb_ready, rf_reg_write, rf_reg_adress, rf_data_write
  );
  modport master (
    output rd_valid, rd_rs1, rd_rs2, op_ready, wb_valid, wb_rd, wb_data, rf_data_read,
    input  rd_ready, op_valid, op_a, op_b, wb_ready, rf_reg_write, rf_reg_adress, rf_data_write
  );
endinterface

// File: rtl/rf_rr_arbiter.sv
// rf_rr_arbiter: two-requester round-robin, the side that did not win last time wins a tie
module rf_rr_arbiter
  import sparc_rf_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rd_req,
  input  logic wb_req,
  output logic gnt_rd,
  output logic gnt_wb
);
  grant_e last_grant;
  assign gnt_rd = rd_req && (!wb_req || last_grant == GRANT_WB);
  assign gnt_wb = wb_req && !gnt_rd;
  always_ff @(posedge clk or posedge rst)
    if (rst) last_grant <= GRANT_WB;
    else if (gnt_rd) last_grant <= GRANT_RD;
    else if (gnt_wb) last_grant <= GRANT_WB;
endmodule

// File: rtl/rf_port_sequencer.sv
// rf_port_sequencer: shares a single-port SPARC register file between operand reads and writebacks
module rf_port_sequencer
  import sparc_rf_pkg::*;
(
  input logic               clk,
  input logic               rst,
  rf_port_sequencer_if.slave bus
);
  state_e            state, state_nx;
  logic [ADDR_W-1:0] rs1_q, rs2_q;
  logic              gnt_rd, gnt_wb;
  // reads only start from IDLE; writebacks may also slip in while operands wait in RESP
  rf_rr_arbiter u_arb (
    .clk    (clk),
    .rst    (rst),
    .rd_req (!rst && bus.rd_valid && state == IDLE),
    .wb_req (!rst && bus.wb_valid && (state == IDLE || state == RESP)),
    .gnt_rd (gnt_rd),
    .gnt_wb (gnt_wb)
  );
  always_comb begin
    bus.rd_ready      = gnt_rd;
    bus.wb_ready      = gnt_wb;
    bus.rf_reg_write  = gnt_wb && bus.wb_rd != G0_ADDR;
    bus.rf_data_write = gnt_wb ? bus.wb_data : '0;
    bus.rf_reg_adress = gnt_wb ? bus.wb_rd : gnt_rd ? bus.rd_rs1 : state == RD_A ? rs2_q : G0_ADDR;
    state_nx          = state == IDLE ? (gnt_rd ? RD_A : IDLE) :
                        state == RD_A ? RD_B :
                        state == RD_B ? RESP :
                        bus.op_ready  ? IDLE : RESP;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      rs1_q        <= '0;
      rs2_q        <= '0;
      bus.op_valid <= 1'b0;
      bus.op_a     <= '0;
      bus.op_b     <= '0;
    end else begin
      state <= state_nx;
      if (gnt_rd) begin
        rs1_q <= bus.rd_rs1;
        rs2_q <= bus.rd_rs2;
      end
      if (state == RD_A) bus.op_a <= rs1_q == G0_ADDR ? '0 : bus.rf_data_read;
      if (state == RD_B) begin
        bus.op_b     <= rs2_q == G0_ADDR ? '0 : bus.rf_data_read;
        bus.op_valid <= 1'b1;
      end
      if (state == RESP && bus.op_ready) bus.op_valid <= 1'b0;
    end
endmodule
